// File: rtl/tt_pwm_multi.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter,
// double-buffered PERIOD/POL/DUTY registers and per-channel polarity.
module tt_pwm_multi #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [N_CH-1:0]  pwm_out,
  output logic [WIDTH-1:0] cnt,
  output logic             period_end
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [3:0] ADDR_PERIOD = 4'd0;
  localparam logic [3:0] ADDR_CTRL   = 4'd1;
  localparam logic [3:0] ADDR_POL    = 4'd2;
  localparam logic [3:0] ADDR_DUTY0  = 4'd3;

  logic [WIDTH-1:0] period_sh, period_act;
  logic [N_CH-1:0]  pol_sh, pol_act;
  logic [WIDTH-1:0] duty_sh  [N_CH];
  logic [WIDTH-1:0] duty_act [N_CH];
  logic             run, center;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             boundary;
  logic             copy_en;
  logic             ctrl_wr;
  logic [N_CH-1:0]  pwm_cmp;

  assign ctrl_wr    = wr_en && (wr_addr == ADDR_CTRL);
  assign copy_en    = !run || boundary;
  assign period_end = boundary;

  // Shadow registers take writes; active registers reload from the shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh  <= '1;
      period_act <= '1;
      pol_sh     <= '0;
      pol_act    <= '0;
      run        <= 1'b0;
      center     <= 1'b0;
      // NOTE: the duty arrays are small flop-based register files, not RAM, so they take the reset like any other state.
      for (int k = 0; k < N_CH; k++) begin
        duty_sh[k]  <= '0;
        duty_act[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make the copy below see the shadows as they were at the start of the cycle.
      if (copy_en) begin
        period_act <= period_sh;
        pol_act    <= pol_sh;
        for (int k = 0; k < N_CH; k++) duty_act[k] <= duty_sh[k];
      end
      if (wr_en && wr_addr == ADDR_PERIOD) period_sh <= wr_data;
      if (wr_en && wr_addr == ADDR_POL)    pol_sh    <= wr_data[N_CH-1:0];
      if (ctrl_wr)                         {center, run} <= wr_data[1:0];
      for (int k = 0; k < N_CH; k++) begin
        if (wr_en && wr_addr == ADDR_DUTY0 + 4'(k)) duty_sh[k] <= wr_data;
      end
    end
  end

  // Counter next-state; IDLE behaves as UP from zero on the first running cycle.
  always_comb begin
    // NOTE: every signal of this block gets a default first, so no path can infer a latch.
    cnt_nxt   = cnt;
    state_nxt = state;
    boundary  = 1'b0;
    if (run && ena) begin
      if (period_act == '0) begin
        cnt_nxt   = '0;
        state_nxt = UP;
      end else if (!center) begin
        cnt_nxt   = (cnt >= period_act) ? '0 : cnt + WIDTH'(1);
        state_nxt = UP;
      end else if (state == DOWN) begin
        cnt_nxt   = (cnt <= WIDTH'(1)) ? '0 : cnt - WIDTH'(1);
        state_nxt = (cnt_nxt == '0) ? UP : DOWN;
      end else if (cnt >= period_act) begin
        cnt_nxt   = period_act - WIDTH'(1);
        state_nxt = (cnt_nxt == '0) ? UP : DOWN;
      end else begin
        cnt_nxt   = cnt + WIDTH'(1);
        state_nxt = UP;
      end
      boundary = (cnt_nxt == '0);
    end
    // CTRL takes effect at the write edge: stopping clears the counter, a mode change restarts counting upward.
    if (ctrl_wr && !wr_data[0]) begin
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else if (ctrl_wr && (wr_data[1] != center) && (state_nxt != IDLE)) begin
      state_nxt = UP;
    end
  end

  always_comb begin
    pwm_cmp = '0;
    for (int k = 0; k < N_CH; k++) pwm_cmp[k] = (cnt < duty_act[k]) ^ pol_act[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pwm_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!run)     pwm_out <= pol_act;
      else if (ena) pwm_out <= pwm_cmp;
    end
  end

endmodule

// File: tb/tb_tt_pwm_multi.sv
// Self-checking bench for tt_pwm_multi (WIDTH=8, N_CH=4): an index-based
// reference model pushes expected cnt/pwm_out/period_end per cycle to a queue.
module tb_tt_pwm_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] pwm_out;
  logic [7:0] cnt;
  logic       period_end;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic [3:0] pwm;
    logic       pe;
  } exp_t;

  exp_t sb[$];

  // Reference model: counter position is a function of the count of enabled cycles.
  int         m_j;
  int         m_top;
  bit         m_center;
  logic [3:0] m_pwm;
  logic [3:0] m_pol;
  logic [7:0] m_act [4];
  logic [7:0] m_sh  [4];

  tt_pwm_multi #(.N_CH(4), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .cnt        (cnt),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int mcnt(input int j);
    int p;
    if (m_top == 0) return 0;
    if (!m_center) return j % (m_top + 1);
    p = j % (2 * m_top);
    return (p <= m_top) ? p : 2 * m_top - p;
  endfunction

  // One configuration cycle; any write lands on the following rising edge.
  task automatic cfg(input logic we, input logic [3:0] a, input logic [7:0] d);
    ena = 1'b1; wr_en = we; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
  endtask

  // One checked cycle: push expectation, drive inputs, wait to the sample point, advance model.
  task automatic mstep(input logic e, input logic we, input logic [3:0] a, input logic [7:0] d);
    exp_t x;
    x.cnt = 8'(mcnt(m_j));
    x.pwm = m_pwm;
    x.pe  = e && (mcnt(m_j + 1) == 0);
    sb.push_back(x);
    ena = e; wr_en = we; wr_addr = a; wr_data = d;
    @(negedge clk);
    if (e) begin
      for (int k = 0; k < 4; k++) m_pwm[k] = (8'(mcnt(m_j)) < m_act[k]) ^ m_pol[k];
      if (mcnt(m_j + 1) == 0) m_act = m_sh;
      m_j++;
    end
    if (we && a >= 4'd3 && a <= 4'd6) m_sh[a - 4'd3] = d;
  endtask

  task automatic start_run(input int t, input bit ctr, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3, input logic [3:0] pol);
    logic [7:0] d [4];
    d = '{d0, d1, d2, d3};
    cfg(1'b1, 4'd1, 8'd0);
    cfg(1'b1, 4'd0, 8'(t));
    for (int k = 0; k < 4; k++) cfg(1'b1, 4'(3 + k), d[k]);
    cfg(1'b1, 4'd2, {4'b0, pol});
    cfg(1'b0, 4'd0, 8'd0);
    cfg(1'b0, 4'd0, 8'd0);
    cfg(1'b1, 4'd1, {6'b0, ctr, 1'b1});
    m_top = t; m_center = ctr; m_j = 0; m_pol = pol; m_pwm = pol;
    for (int k = 0; k < 4; k++) begin
      m_act[k] = d[k];
      m_sh[k]  = d[k];
    end
  endtask

  task automatic test_reset();
    exp_t x;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("FAIL reset cnt: got %0d expected 0", cnt); end
    checks++;
    if (pwm_out !== 4'd0) begin errors++; $display("FAIL reset pwm_out: got %b expected 0000", pwm_out); end
    checks++;
    if (period_end !== 1'b0) begin errors++; $display("FAIL reset period_end: got %b expected 0", period_end); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{cnt: 8'd0, pwm: 4'd0, pe: 1'b0});
      ena = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_edge();
    exp_t x;
    start_run(9, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 4'h0);
    for (int i = 0; i < 30; i++) begin
      mstep(1'b1, 1'b0, 4'd0, 8'd0);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL edge cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_duty_pol();
    exp_t x;
    start_run(9, 1'b0, 8'd0, 8'd10, 8'd5, 8'd0, 4'h4);
    for (int i = 0; i < 20; i++) begin
      mstep(1'b1, 1'b0, 4'd0, 8'd0);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL duty_pol cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_center();
    exp_t x;
    start_run(4, 1'b1, 8'd2, 8'd0, 8'd0, 8'd0, 4'h0);
    for (int i = 0; i < 24; i++) begin
      mstep(1'b1, 1'b0, 4'd0, 8'd0);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL center cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shadow();
    exp_t x;
    logic we;
    start_run(9, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 4'h0);
    for (int i = 0; i < 40; i++) begin
      we = (i == 4) || (i == 19);
      mstep(1'b1, we, 4'd3, (i == 4) ? 8'd7 : 8'd5);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL shadow cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ena_hold();
    exp_t x;
    start_run(9, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 4'h0);
    for (int i = 0; i < 25; i++) begin
      mstep(!(i >= 5 && i < 10), (i == 7), 4'd3, 8'd6);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL ena_hold cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_top_zero();
    exp_t x;
    for (int m = 0; m < 2; m++) begin
      start_run(0, m[0], 8'd1, 8'd0, 8'd0, 8'd0, (m == 0) ? 4'h0 : 4'h2);
      for (int i = 0; i < 6; i++) begin
        mstep(i != 3, 1'b0, 4'd0, 8'd0);
        x = sb.pop_front();
        checks++;
        if ({cnt, pwm_out, period_end} !== x) begin
          errors++;
          $display("FAIL top_zero mode %0d cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                   m, i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    start_run(9, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      mstep(1'b1, 1'b0, 4'd0, 8'd0);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL reset_mid pre cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("FAIL reset_mid async cnt: got %0d expected 0", cnt); end
    checks++;
    if (pwm_out !== 4'd0) begin errors++; $display("FAIL reset_mid async pwm_out: got %b expected 0000", pwm_out); end
    checks++;
    if (period_end !== 1'b0) begin errors++; $display("FAIL reset_mid async period_end: got %b expected 0", period_end); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{cnt: 8'd0, pwm: 4'd0, pe: 1'b0});
      ena = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL reset_mid stopped cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
    // Only RUN is written: the counter must span the reset PERIOD of 255.
    cfg(1'b1, 4'd1, 8'd1);
    m_top = 255; m_center = 1'b0; m_j = 0; m_pol = 4'h0; m_pwm = 4'h0;
    for (int k = 0; k < 4; k++) begin
      m_act[k] = 8'd0;
      m_sh[k]  = 8'd0;
    end
    for (int i = 0; i < 260; i++) begin
      mstep(1'b1, 1'b0, 4'd0, 8'd0);
      x = sb.pop_front();
      checks++;
      if ({cnt, pwm_out, period_end} !== x) begin
        errors++;
        $display("FAIL reset_mid period255 cycle %0d: got cnt=%0d pwm=%b pe=%b expected cnt=%0d pwm=%b pe=%b",
                 i, cnt, pwm_out, period_end, x.cnt, x.pwm, x.pe);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_duty_pol();
    test_center();
    test_shadow();
    test_ena_hold();
    test_top_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_pwm_multi.md
TT_PWM_MULTI -- requirements
Module: tt_pwm_multi

Interface
REQ-001 SHALL provide parameter N_CH, default 4, number of PWM channels (1..8, N_CH <= WIDTH).
REQ-002 SHALL provide parameter WIDTH, default 8, counter/duty/period width (4..16).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ena  input  1  counter advance enable; low = full hold.
REQ-006 SHALL have port wr_en  input  1  register write strobe, one write per cycle.
REQ-007 SHALL have port wr_addr  input  4  register address.
REQ-008 SHALL have port wr_data  input  WIDTH  register write data.
REQ-009 SHALL have port pwm_out  output  N_CH  registered PWM outputs.
REQ-010 SHALL have port cnt  output  WIDTH  current counter value.
REQ-011 SHALL have port period_end  output  1  one-cycle pulse marking a period boundary.

Function
REQ-012 SHALL decode: addr 0 PERIOD (TOP); addr 1 CTRL (bit0 RUN, bit1 CENTER); addr 2 POL (bits [N_CH-1:0]); addr 3+k DUTY[k]; other addresses ignored.
REQ-013 SHALL write wr_data into the shadow copy of the addressed register on any clk edge with wr_en=1.
REQ-014 SHALL copy all shadows to active registers in a boundary cycle, or in every cycle while active RUN=0; CTRL applies immediately, PERIOD/POL/DUTY only via this copy.
REQ-015 SHALL use shadow contents as of the start of the cycle for the copy; a write coincident with a boundary takes effect at the following boundary.
REQ-016 SHALL implement counter FSM states IDLE, UP, DOWN.
REQ-017 SHALL, when RUN=0: state IDLE, cnt=0, pwm_out[k]=POL[k], period_end=0.
REQ-018 SHALL, when RUN=1 and ena=0: hold cnt, state, pwm_out; period_end=0; register writes still accepted.
REQ-019 SHALL, edge mode (CENTER=0), RUN=1, ena=1: cnt increments 0..TOP, then wraps to 0; period TOP+1 cycles.
REQ-020 SHALL, center mode, RUN=1, ena=1: UP increments; at cnt==TOP next cnt=TOP-1, state DOWN; DOWN decrements; state becomes UP whenever next cnt is 0; sequence 0..TOP..1; period 2*TOP cycles.
REQ-021 SHALL leave IDLE to UP with cnt=0 on first cycle RUN=1.
REQ-022 SHALL treat TOP=0 as cnt fixed at 0, boundary every enabled cycle, in both modes.
REQ-023 SHALL define boundary cycle as RUN=1, ena=1 and next cnt equals 0 (edge: cnt==TOP; center: next value 0).
REQ-024 SHALL assert period_end combinationally high exactly in boundary cycles.
REQ-025 SHALL register pwm_out[k] = (cnt < DUTY[k]) XOR POL[k], evaluated on the current cnt; pwm_out lags cnt by one cycle.
REQ-026 SHALL give DUTY=0 constant inactive level and DUTY>TOP constant active level (edge mode) with no glitches.
REQ-027 SHALL switch CENTER mid-run such that counter continues from its present value in the new mode, state UP.
REQ-028 SHALL compare unsigned, WIDTH bits, no overflow beyond 2^WIDTH-1.

Reset
REQ-029 SHALL, on rst_n low, asynchronously set cnt=0, state IDLE, pwm_out=0, period_end=0.
REQ-030 SHALL reset shadow and active PERIOD to 2^WIDTH-1, CTRL=0, POL=0, all DUTY=0.
REQ-031 SHALL resume only after rst_n deasserts synchronously to clk; reset mid-period discards all register contents.

Verification (WIDTH=8, N_CH=4)
REQ-032 SHALL cover: PERIOD=9, DUTY0=3, RUN=1 edge -> pwm_out[0] high 3 of every 10 cycles, period_end every 10 cycles at cnt==9.
REQ-033 SHALL cover: DUTY0=0, DUTY1=10, DUTY2=5 with POL=0x4, PERIOD=9 -> ch0 always 0, ch1 always 1, ch2 low 5/high 5 per period.
REQ-034 SHALL cover: CTRL=0x3, PERIOD=4, DUTY0=2 -> cnt 0,1,2,3,4,3,2,1 repeating, pwm_out[0] high 3 of 8 cycles, period_end when cnt==1 in DOWN.
REQ-035 SHALL cover: DUTY0 3->7 written mid-period and again at a boundary cycle -> first change visible only after next cnt==0, coincident write one period later.
REQ-036 SHALL cover: ena low 5 cycles mid-period -> cnt, pwm_out frozen, period_end 0; resumes without lost counts.
REQ-037 SHALL cover: rst_n pulsed low mid-run -> outputs 0 immediately (before next clk edge), PERIOD reads back effect 255, RUN=0.
